// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/bubble sequencer for the 5-stage RV32 core
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int BUS_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [31:0]       jump_addr_i,
  input  logic              ex_is_load_i,
  input  logic [4:0]        ex_rd_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic              muldiv_start_i,
  input  logic              muldiv_done_i,
  input  logic              bus_req_i,
  input  logic              bus_ack_i,
  output logic [3:0]        stall_o,
  output logic              bubble_o,
  output logic              flush_o,
  output logic              jump_o,
  output logic [31:0]       jump_addr_o,
  output logic              bus_err_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TM_W = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_MULDIV, S_FLUSH, S_BUS} state_t;

  state_t             r_state, w_state_next;
  logic [FC_W-1:0]    r_flush_cnt, w_flush_cnt_next;
  logic [TM_W-1:0]    r_bus_timer, w_bus_timer_next, w_timer_inc;
  logic               r_done_seen, w_done_seen_next;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic               w_bus_wait, w_load_use, w_timer_hit, w_eval_idle;
  logic [3:0]         w_stall;
  logic               w_bubble, w_flush, w_jump, w_bus_err;
  logic [31:0]        w_jump_addr;

  assign w_bus_wait  = bus_req_i & ~bus_ack_i;
  assign w_load_use  = ex_is_load_i & (ex_rd_i != 5'd0) &
                       ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
  assign w_timer_inc = r_bus_timer + TM_W'(1);
  assign w_timer_hit = (w_timer_inc >= TM_W'(BUS_TIMEOUT));

  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_bus_timer_next = r_bus_timer;
    w_done_seen_next = r_done_seen;
    w_stall          = 4'b0000;
    w_bubble         = 1'b0;
    w_flush          = 1'b0;
    w_jump           = 1'b0;
    w_jump_addr      = 32'h0;
    w_bus_err        = 1'b0;
    w_eval_idle      = 1'b0;

    case (r_state)
      S_IDLE: w_eval_idle = 1'b1;
      S_MULDIV: begin
        if (w_bus_wait) begin
          w_stall = 4'b1111;
          if (muldiv_done_i) w_done_seen_next = 1'b1;
        end else if (muldiv_done_i || r_done_seen) begin
          w_state_next     = S_IDLE;
          w_done_seen_next = 1'b0;
        end else begin
          w_stall = 4'b0111;
        end
      end
      S_FLUSH: begin
        if (w_bus_wait) begin
          w_stall = 4'b1111;
        end else begin
          w_flush = 1'b1;
          if (r_flush_cnt <= FC_W'(1)) w_state_next = S_IDLE;
          else w_flush_cnt_next = r_flush_cnt - FC_W'(1);
        end
      end
      S_BUS: begin
        // The release cycle acts as IDLE so a re-presented jump/load is not lost.
        if (!w_bus_wait) begin
          w_eval_idle = 1'b1;
        end else if (w_timer_hit) begin
          w_bus_err    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_stall          = 4'b1111;
          w_bus_timer_next = w_timer_inc;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    if (w_eval_idle) begin
      w_state_next = S_IDLE;
      if (w_bus_wait) begin
        w_stall          = 4'b1111;
        w_state_next     = S_BUS;
        w_bus_timer_next = TM_W'(1);
      end else if (muldiv_start_i) begin
        if (!muldiv_done_i) begin
          w_stall          = 4'b0111;
          w_state_next     = S_MULDIV;
          w_done_seen_next = 1'b0;
        end
      end else if (jump_en_i) begin
        w_jump      = 1'b1;
        w_jump_addr = jump_addr_i;
        w_flush     = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          w_state_next     = S_FLUSH;
          w_flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
        end
      end else if (w_load_use) begin
        w_stall  = 4'b0011;
        w_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
      r_bus_timer <= '0;
      r_done_seen <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_bus_timer <= w_bus_timer_next;
      r_done_seen <= w_done_seen_next;
      if (w_stall[0] && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_o     = rst ? 4'b0000 : w_stall;
  assign bubble_o    = ~rst & w_bubble;
  assign flush_o     = ~rst & w_flush;
  assign jump_o      = ~rst & w_jump;
  assign jump_addr_o = rst ? 32'h0 : w_jump_addr;
  assign bus_err_o   = ~rst & w_bus_err;
  assign stall_cnt_o = rst ? '0 : r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_i, id_rs1_i, id_rs2_i;
  logic        muldiv_start_i, muldiv_done_i;
  logic        bus_req_i, bus_ack_i;
  logic [3:0]  stall_o;
  logic        bubble_o, flush_o, jump_o, bus_err_o;
  logic [31:0] jump_addr_o;
  logic [5:0]  stall_cnt_o;
  logic [7:0]  w_obs;

  int n_total = 0;
  int n_pass  = 0;

  pipe_ctrl #(.FLUSH_CYCLES(2), .BUS_TIMEOUT(8), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .muldiv_start_i(muldiv_start_i), .muldiv_done_i(muldiv_done_i),
    .bus_req_i(bus_req_i), .bus_ack_i(bus_ack_i),
    .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
    .jump_o(jump_o), .jump_addr_o(jump_addr_o), .bus_err_o(bus_err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  // {stall[3:0], bubble, flush, jump, bus_err}
  assign w_obs = {stall_o, bubble_o, flush_o, jump_o, bus_err_o};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic clr;
    jump_en_i = 0; jump_addr_i = 32'h0; ex_is_load_i = 0;
    ex_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
    muldiv_start_i = 0; muldiv_done_i = 0; bus_req_i = 0; bus_ack_i = 0;
  endtask

  initial begin
    clr();
    rst = 1;
    settle();
    check("rst_outs", w_obs, 8'h00);
    check("rst_cnt", stall_cnt_o, 0);
    check("rst_addr", jump_addr_o, 32'h0);
    cyc(); cyc();
    rst = 0;

    // mul/div for 33 stall cycles
    muldiv_start_i = 1;
    settle(); check("md_start", w_obs, 8'h70); cyc();
    muldiv_start_i = 0;
    for (int i = 1; i < 33; i++) begin
      settle(); check("md_hold", w_obs, 8'h70); cyc();
    end
    muldiv_done_i = 1;
    settle(); check("md_done", w_obs, 8'h00); cyc();
    muldiv_done_i = 0;
    settle(); check("md_idle", w_obs, 8'h00); check("md_cnt", stall_cnt_o, 33); cyc();

    // load-use
    ex_is_load_i = 1; ex_rd_i = 5; id_rs2_i = 5;
    settle(); check("lu_rs2", w_obs, 8'h38); cyc();
    clr();
    settle(); check("lu_after", w_obs, 8'h00); cyc();
    ex_is_load_i = 1; ex_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
    settle(); check("lu_x0", w_obs, 8'h00); cyc();
    ex_is_load_i = 1; ex_rd_i = 7; id_rs1_i = 7; id_rs2_i = 3;
    settle(); check("lu_rs1", w_obs, 8'h38); cyc();
    ex_is_load_i = 0;
    settle(); check("lu_noload", w_obs, 8'h00); check("lu_cnt", stall_cnt_o, 35); cyc();
    clr();

    // jump with two flush cycles; second-cycle jump/load-use ignored
    jump_en_i = 1; jump_addr_i = 32'h0000_0100;
    settle(); check("jmp", w_obs, 8'h06); check("jmp_addr", jump_addr_o, 32'h100); cyc();
    ex_is_load_i = 1; ex_rd_i = 5; id_rs1_i = 5;
    settle(); check("jmp_flush2", w_obs, 8'h04); check("jmp_addr2", jump_addr_o, 32'h0); cyc();
    clr();
    settle(); check("jmp_done", w_obs, 8'h00); cyc();

    // bus wait, ack on cycle 5, jump/load-use masked meanwhile
    bus_req_i = 1; jump_en_i = 1; jump_addr_i = 32'h200;
    ex_is_load_i = 1; ex_rd_i = 9; id_rs2_i = 9;
    for (int i = 1; i <= 4; i++) begin
      settle(); check("bus_wait", w_obs, 8'hF0); cyc();
    end
    clr(); bus_req_i = 1; bus_ack_i = 1;
    settle(); check("bus_ack", w_obs, 8'h00); cyc();
    clr(); jump_en_i = 1; jump_addr_i = 32'h200;
    settle(); check("bus_jmp", w_obs, 8'h06); check("bus_jmp_addr", jump_addr_o, 32'h200); cyc();
    clr();
    settle(); check("bus_flush", w_obs, 8'h04); cyc();
    settle(); check("bus_idle", w_obs, 8'h00); check("bus_cnt", stall_cnt_o, 39); cyc();

    // bus timeout at cycle 8
    bus_req_i = 1;
    for (int i = 1; i <= 7; i++) begin
      settle(); check("to_wait", w_obs, 8'hF0); cyc();
    end
    settle(); check("to_err", w_obs, 8'h01); cyc();
    clr(); ex_is_load_i = 1; ex_rd_i = 4; id_rs1_i = 4;
    settle(); check("to_idle", w_obs, 8'h38); cyc();
    clr();
    settle(); check("to_quiet", w_obs, 8'h00); check("to_cnt", stall_cnt_o, 47); cyc();

    // mul/div done arriving under bus wait
    muldiv_start_i = 1;
    settle(); check("mdb_start", w_obs, 8'h70); cyc();
    muldiv_start_i = 0; bus_req_i = 1; muldiv_done_i = 1;
    settle(); check("mdb_done_wait", w_obs, 8'hF0); cyc();
    muldiv_done_i = 0;
    settle(); check("mdb_wait", w_obs, 8'hF0); cyc();
    bus_req_i = 0;
    settle(); check("mdb_release", w_obs, 8'h00); cyc();
    settle(); check("mdb_idle", w_obs, 8'h00); check("mdb_cnt", stall_cnt_o, 50); cyc();

    // counter saturation: 20 more stall cycles past 50 with a 6-bit counter
    muldiv_start_i = 1;
    settle(); cyc();
    muldiv_start_i = 0;
    for (int i = 0; i < 19; i++) cyc();
    muldiv_done_i = 1;
    settle(); check("sat_done", w_obs, 8'h00); cyc();
    muldiv_done_i = 0;
    settle(); check("sat_cnt", stall_cnt_o, 63); cyc();

    // reset mid-MULDIV
    muldiv_start_i = 1;
    settle(); cyc();
    muldiv_start_i = 0;
    cyc(); cyc();
    rst = 1;
    settle(); check("rmd_outs", w_obs, 8'h00); check("rmd_cnt", stall_cnt_o, 0); cyc();
    rst = 0;
    settle(); check("rmd_idle", w_obs, 8'h00); check("rmd_cnt2", stall_cnt_o, 0); cyc();

    // reset mid-BUS
    bus_req_i = 1;
    settle(); check("rbus_wait", w_obs, 8'hF0); cyc();
    cyc();
    rst = 1;
    settle(); check("rbus_outs", w_obs, 8'h00); cyc();
    rst = 0; bus_req_i = 0;
    settle(); check("rbus_idle", w_obs, 8'h00); check("rbus_cnt", stall_cnt_o, 0); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
